// File: rtl/max_unpool_seq.sv
// Sequential max-unpooling stage.
// Accepts one pooled value plus its window-local argmax position per cycle.
// Rebuilds the INPUT_SIZE x INPUT_SIZE map from these, then holds it for the
// consumer until the consumer accepts it.
module max_unpool_seq #(
  parameter int INPUT_SIZE   = 4,
  parameter int POOLING_SIZE = 2,
  parameter int DATA_WIDTH   = 32,
  localparam int IDX_W = (POOLING_SIZE * POOLING_SIZE > 1) ? $clog2(POOLING_SIZE * POOLING_SIZE) : 1
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            in_valid,
  output logic                                            in_ready,
  input  logic [DATA_WIDTH-1:0]                           in_data,
  input  logic [IDX_W-1:0]                                in_index,
  output logic                                            out_valid,
  input  logic                                            out_ready,
  output logic [INPUT_SIZE*INPUT_SIZE-1:0][DATA_WIDTH-1:0] out_map,
  output logic                                            idx_err
);

  localparam int OUT_SIZE = INPUT_SIZE / POOLING_SIZE;
  localparam int NELEM    = INPUT_SIZE * INPUT_SIZE;
  localparam int WIN      = POOLING_SIZE * POOLING_SIZE;
  localparam int CW       = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(OUT_SIZE - 1);

  typedef enum logic {FILL, HOLD} state_t;

  state_t                            state, state_next;
  logic [CW-1:0]                     win_row, win_col;
  logic                              accept, last_win, idx_ok;
  logic [31:0]                       target;
  logic [NELEM-1:0][DATA_WIDTH-1:0]  map_q;

  assign accept   = in_valid && in_ready;
  assign last_win = (win_row == LAST) && (win_col == LAST);
  assign idx_ok   = int'(in_index) < WIN;
  assign out_map  = map_q;

  // Flat buffer position of the current window's argmax element
  always_comb begin
    target = (32'(win_row) * POOLING_SIZE + 32'(in_index) / POOLING_SIZE) * INPUT_SIZE
           + 32'(win_col) * POOLING_SIZE + 32'(in_index) % POOLING_SIZE;
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= FILL;
    else        state <= state_next;
  end

  // Next-state logic: fill all windows, then hold until the map is taken
  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (accept && last_win) state_next = HOLD;
      HOLD:    if (out_ready)          state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  // Handshake outputs; in_ready is also gated by rst_n so it stays low during reset
  always_comb begin
    in_ready  = rst_n && (state == FILL);
    out_valid = (state == HOLD);
  end

  // Map buffer, window counter and sticky index error
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      map_q   <= '0;
      win_row <= '0;
      win_col <= '0;
      idx_err <= 1'b0;
    end else if (out_valid && out_ready) begin
      map_q   <= '0;
      idx_err <= 1'b0;
    end else if (accept) begin
      if (idx_ok) begin
        for (int unsigned i = 0; i < NELEM; i++) begin
          if (i == target) map_q[i] <= in_data;
        end
      end else begin
        idx_err <= 1'b1;
      end
      // Row/column pair stands in for w, avoiding a divide by OUT_SIZE
      if (win_col == LAST) begin
        win_col <= '0;
        win_row <= (win_row == LAST) ? '0 : win_row + 1'b1;
      end else begin
        win_col <= win_col + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_max_unpool_seq.sv
// Self-checking bench for max_unpool_seq: a 4x4/2 instance and a 6x6/3 instance,
// each compared against a window-arithmetic reference map.
module tb_max_unpool_seq;

  localparam int A_IS = 4, A_P = 2, A_OS = 2;
  localparam int B_IS = 6, B_P = 3, B_OS = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic               a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_idx_err;
  logic [31:0]        a_in_data;
  logic [1:0]         a_in_index;
  logic [15:0][31:0]  a_out_map;

  logic               b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_idx_err;
  logic [31:0]        b_in_data;
  logic [3:0]         b_in_index;
  logic [35:0][31:0]  b_out_map;

  max_unpool_seq #(.INPUT_SIZE(A_IS), .POOLING_SIZE(A_P), .DATA_WIDTH(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_index(a_in_index), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_map(a_out_map), .idx_err(a_idx_err));

  max_unpool_seq #(.INPUT_SIZE(B_IS), .POOLING_SIZE(B_P), .DATA_WIDTH(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_index(b_in_index), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_map(b_out_map), .idx_err(b_idx_err));

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0][31:0] exp_a;
  int                a_k;
  logic              exp_a_err;
  logic [35:0][31:0] exp_b;
  int                b_k;
  logic              exp_b_err;

  task automatic chk(input string tag, input bit ok);
    n_checks++;
    assert (ok) else begin
      n_fail++;
      $error("FAIL %s", tag);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: place each value at its window origin plus argmax offset
  task automatic a_clear();
    exp_a = '0; a_k = 0; exp_a_err = 1'b0;
  endtask

  task automatic a_model(input logic [31:0] d, input int idx);
    int r, c;
    r = a_k / A_OS;
    c = a_k % A_OS;
    if (idx < A_P * A_P) exp_a[(r * A_P + idx / A_P) * A_IS + c * A_P + idx % A_P] = d;
    else exp_a_err = 1'b1;
    a_k++;
  endtask

  task automatic b_clear();
    exp_b = '0; b_k = 0; exp_b_err = 1'b0;
  endtask

  task automatic b_model(input logic [31:0] d, input int idx);
    int r, c;
    r = b_k / B_OS;
    c = b_k % B_OS;
    if (idx < B_P * B_P) exp_b[(r * B_P + idx / B_P) * B_IS + c * B_P + idx % B_P] = d;
    else exp_b_err = 1'b1;
    b_k++;
  endtask

  task automatic a_check(input string tag);
    chk(tag, a_out_map === exp_a);
    chk("a_out_valid", a_out_valid === (a_k == A_OS * A_OS));
    chk("a_idx_err", a_idx_err === exp_a_err);
  endtask

  task automatic b_check(input string tag);
    chk(tag, b_out_map === exp_b);
    chk("b_out_valid", b_out_valid === (b_k == B_OS * B_OS));
    chk("b_idx_err", b_idx_err === exp_b_err);
  endtask

  task automatic a_send(input logic [31:0] d, input int idx);
    a_in_valid = 1'b1; a_in_data = d; a_in_index = 2'(idx);
    chk("a_in_ready", a_in_ready === 1'b1);
    step();
    a_model(d, idx);
    a_in_valid = 1'b0;
    a_check("a_map_fill");
  endtask

  task automatic b_send(input logic [31:0] d, input int idx);
    b_in_valid = 1'b1; b_in_data = d; b_in_index = 4'(idx);
    chk("b_in_ready", b_in_ready === 1'b1);
    step();
    b_model(d, idx);
    b_in_valid = 1'b0;
    b_check("b_map_fill");
  endtask

  task automatic a_idle();
    a_in_valid = 1'b0; a_in_data = 32'd77; a_in_index = 2'd3;
    step();
    a_check("a_map_idle");
  endtask

  task automatic a_drain();
    a_out_ready = 1'b1;
    step();
    a_out_ready = 1'b0;
    a_clear();
    a_check("a_map_cleared");
    chk("a_in_ready_after", a_in_ready === 1'b1);
  endtask

  task automatic b_drain();
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0;
    b_clear();
    b_check("b_map_cleared");
    chk("b_in_ready_after", b_in_ready === 1'b1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'd55; a_in_index = 2'd1; a_out_ready = 1'b0;
    b_in_valid = 1'b1; b_in_data = 32'd55; b_in_index = 4'd1; b_out_ready = 1'b0;
    a_clear();
    b_clear();

    // Reset held with in_valid asserted
    repeat (3) begin
      step();
      chk("a_rst_in_ready", a_in_ready === 1'b0);
      chk("b_rst_in_ready", b_in_ready === 1'b0);
      a_check("a_rst_map");
      b_check("b_rst_map");
    end
    rst_n = 1'b1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    #1;
    chk("a_release_in_ready", a_in_ready === 1'b1);
    chk("b_release_in_ready", b_in_ready === 1'b1);

    // Basic back-to-back fill
    a_send(32'd10, 0);
    a_send(32'd20, 1);
    a_send(32'd30, 2);
    a_send(32'd40, 3);
    chk("a_basic_0", a_out_map[0] === 32'd10);
    chk("a_basic_3", a_out_map[3] === 32'd20);
    chk("a_basic_12", a_out_map[12] === 32'd30);
    chk("a_basic_15", a_out_map[15] === 32'd40);

    // Output hold while the consumer stalls; input traffic must be ignored
    a_in_valid = 1'b1; a_in_data = 32'd99; a_in_index = 2'd0;
    repeat (5) begin
      step();
      chk("a_hold_in_ready", a_in_ready === 1'b0);
      a_check("a_hold_map");
    end
    a_in_valid = 1'b0;
    a_drain();

    // Input backpressure: bubbles between beats
    a_send(32'd10, 0); a_idle();
    a_send(32'd20, 1); a_idle();
    a_send(32'd30, 2); a_idle();
    a_send(32'd40, 3);
    chk("a_bp_0", a_out_map[0] === 32'd10);
    chk("a_bp_15", a_out_map[15] === 32'd40);
    a_drain();

    // Randomized maps with random gaps and consumer stalls
    repeat (20) begin
      for (int w = 0; w < A_OS * A_OS; w++) begin
        repeat ($urandom_range(0, 2)) a_idle();
        a_send($urandom, int'($urandom_range(0, 3)));
      end
      repeat ($urandom_range(0, 3)) a_idle();
      a_drain();
    end

    // Reset mid-fill discards the partial map
    a_send(32'd111, 0);
    a_send(32'd222, 3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    a_clear();
    a_check("a_midfill_rst_map");
    a_send(32'd1, 1);
    a_send(32'd2, 0);
    a_send(32'd3, 3);
    a_send(32'd4, 2);
    chk("a_old_0_gone", a_out_map[0] === 32'd0);
    chk("a_old_3_gone", a_out_map[3] === 32'd0);
    chk("a_new_13", a_out_map[13] === 32'd3);

    // Reset while holding a complete map
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    a_clear();
    a_check("a_midhold_rst_map");

    // Invalid index on a 3x3 window
    b_send(32'd500, 9);
    chk("b_err_set", b_idx_err === 1'b1);
    b_send(32'd501, 4);
    b_send(32'd502, 8);
    b_send(32'd503, 0);
    chk("b_pos_10", b_out_map[10] === 32'd501);
    chk("b_pos_32", b_out_map[32] === 32'd502);
    chk("b_pos_21", b_out_map[21] === 32'd503);
    chk("b_err_hold", b_idx_err === 1'b1);
    b_drain();

    // Randomized maps including out-of-range indices
    repeat (12) begin
      for (int w = 0; w < B_OS * B_OS; w++) begin
        b_send($urandom, int'($urandom_range(0, 15)));
      end
      repeat ($urandom_range(0, 2)) begin
        step();
        b_check("b_hold_map");
      end
      b_drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
